// File: rtl/msb_serializer_if.sv
// Word-in / bit-out bus for the MSB-first serializer.
// The master side is the upstream word source together with the serial consumer.
interface msb_serializer_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         abort;
    logic         out_valid;
    logic         out_bit;
    logic         out_first;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid,
        output in_data,
        output abort,
        input  in_ready,
        input  out_valid,
        input  out_bit,
        input  out_first,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  abort,
        output in_ready,
        output out_valid,
        output out_bit,
        output out_first,
        output out_last,
        output busy
    );
endinterface

// File: rtl/msb_serializer.sv
// Parallel-to-serial converter: W-bit words in, one bit per clock out, MSB first.
// A one-word holding buffer lets back-to-back words stream with no idle bit slots.
module msb_serializer #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              reset,
    msb_serializer_if.slave   bus
);
    localparam int unsigned   CW       = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_sh;
    logic [W-1:0]  w_sh_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  r_hold;
    logic [W-1:0]  w_hold_nxt;
    logic          r_hold_valid;
    logic          w_hold_valid_nxt;

    logic          w_sh_valid;
    logic          w_accept;
    logic          w_load_slot;

    assign w_sh_valid  = (r_state == SHIFT);
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_load_slot = !w_sh_valid || (r_cnt == CNT_LAST);

    // Serial outputs come straight from state registers, so reset clears them at once.
    assign bus.in_ready  = !r_hold_valid && !bus.abort;
    assign bus.out_valid = w_sh_valid;
    assign bus.out_bit   = w_sh_valid && r_sh[W-1];
    assign bus.out_first = w_sh_valid && (r_cnt == '0);
    assign bus.out_last  = w_sh_valid && (r_cnt == CNT_LAST);
    assign bus.busy      = w_sh_valid || r_hold_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh         <= w_sh_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

    // Next state: abort flushes; a load slot takes the held word first, else bypasses input.
    always_comb begin
        w_state_nxt      = r_state;
        w_sh_nxt         = r_sh;
        w_cnt_nxt        = r_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;

        if (bus.abort) begin
            w_state_nxt      = IDLE;
            w_hold_valid_nxt = 1'b0;
            w_cnt_nxt        = '0;
        end else if (w_load_slot) begin
            if (r_hold_valid) begin
                w_sh_nxt         = r_hold;
                w_hold_valid_nxt = 1'b0;
                w_cnt_nxt        = '0;
                w_state_nxt      = SHIFT;
            end else if (w_accept) begin
                w_sh_nxt    = bus.in_data;
                w_cnt_nxt   = '0;
                w_state_nxt = SHIFT;
            end else begin
                w_state_nxt = IDLE;
            end
        end else begin
            w_sh_nxt  = {r_sh[W-2:0], 1'b0};
            w_cnt_nxt = r_cnt + CW'(1);
            if (w_accept) begin
                w_hold_nxt       = bus.in_data;
                w_hold_valid_nxt = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_msb_serializer.sv
// Self-checking bench for msb_serializer: directed scenarios plus random traffic
// checked against a word-FIFO reference model and an in-order word scoreboard.
module tb_msb_serializer;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    msb_serializer_if #(.W(W)) bus  ();
    msb_serializer_if #(.W(2)) bus2 ();

    msb_serializer #(.W(W)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    msb_serializer #(.W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: FIFO of accepted-but-unstarted words plus the word being sent.
    logic [W-1:0] m_pend[$];
    logic         m_cur_valid;
    logic [W-1:0] m_cur;
    int           m_pos;

    // Scoreboard: words rebuilt from the serial stream must match acceptance order.
    logic [W-1:0] sb_acc[$];
    logic [W-1:0] sb_word;
    int           sb_bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_cur_valid = 1'b0;
        m_cur       = '0;
        m_pos       = 0;
        sb_acc.delete();
        sb_word     = '0;
        sb_bits     = 0;
    endtask

    task automatic check_outputs();
        logic       e_bit;
        logic [W-1:0] e_word;
        e_bit = m_cur_valid ? m_cur[W-1-m_pos] : 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'(m_cur_valid));
        chk("out_bit",   32'(bus.out_bit),   32'(e_bit));
        chk("out_first", 32'(bus.out_first), 32'(m_cur_valid && m_pos == 0));
        chk("out_last",  32'(bus.out_last),  32'(m_cur_valid && m_pos == int'(W) - 1));
        chk("busy",      32'(bus.busy),      32'(m_cur_valid || m_pend.size() != 0));
        if (bus.out_valid === 1'b1) begin
            if (bus.out_first === 1'b1) sb_bits = 0;
            sb_word = {sb_word[W-2:0], bus.out_bit};
            sb_bits++;
            if (bus.out_last === 1'b1) begin
                e_word = 'x;
                if (sb_acc.size() != 0) e_word = sb_acc.pop_front();
                chk("word_order", 32'(sb_word), 32'(e_word));
                chk("word_len",   32'(sb_bits), 32'(W));
                sb_bits = 0;
            end
        end
    endtask

    // One clock: drive at negedge, check in_ready, update model at posedge, check outputs.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic ab, output logic acc);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.abort    = ab;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!ab && m_pend.size() == 0));
        acc = v && !ab && (m_pend.size() == 0);
        @(posedge clk);
        if (ab) begin
            m_pend.delete();
            m_cur_valid = 1'b0;
            sb_acc.delete();
            sb_bits = 0;
        end else begin
            if (acc) begin
                m_pend.push_back(d);
                sb_acc.push_back(d);
            end
            if (!m_cur_valid || m_pos == int'(W) - 1) begin
                if (m_pend.size() != 0) begin
                    m_cur       = m_pend.pop_front();
                    m_pos       = 0;
                    m_cur_valid = 1'b1;
                end else begin
                    m_cur_valid = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, a);
    endtask

    initial begin
        logic         a;
        logic [3:0]   w2_bits, w2_first, w2_last;
        logic [W-1:0] tx[$];
        int           idx, budget;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        bus2.abort    = 1'b0;
        model_reset();

        // Reset values
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_bit",   32'(bus.out_bit),   32'(0));
        chk("rst_out_first", 32'(bus.out_first), 32'(0));
        chk("rst_out_last",  32'(bus.out_last),  32'(0));
        chk("rst_busy",      32'(bus.busy),      32'(0));
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_w2_busy",   32'(bus2.busy),     32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // W=2 build: 2'b10 then 2'b01 back to back
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = (i < 2);
            bus2.in_data  = (i == 0) ? 2'b10 : 2'b01;
            if (i < 2) begin
                #1;
                chk("w2_in_ready", 32'(bus2.in_ready), 32'(1));
            end
            @(posedge clk);
            @(negedge clk);
            if (i < 4) begin
                w2_bits[3-i]  = bus2.out_bit;
                w2_first[3-i] = bus2.out_first;
                w2_last[3-i]  = bus2.out_last;
            end
        end
        bus2.in_valid = 1'b0;
        chk("w2_bits",      32'(w2_bits),         32'(4'b1001));
        chk("w2_first",     32'(w2_first),        32'(4'b1010));
        chk("w2_last",      32'(w2_last),         32'(4'b0101));
        chk("w2_idle_valid", 32'(bus2.out_valid), 32'(0));
        chk("w2_idle_busy",  32'(bus2.busy),      32'(0));

        // Single word 8'h03
        cycle(1'b1, 8'h03, 1'b0, a);
        idle(9);

        // Back-to-back A5, 3C, FF with in_valid held high
        tx = '{8'hA5, 8'h3C, 8'hFF};
        idx = 0;
        budget = 40;
        while (idx < 3 && budget > 0) begin
            cycle(1'b1, tx[idx], 1'b0, a);
            if (a) idx++;
            budget--;
        end
        idle(20);

        // Bypass: each new word offered exactly in the out_last cycle
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, W'($urandom), 1'b0, a);
            idle(7);
        end
        idle(2);

        // Abort during bit 3 of A5 with 3C held; in_valid during abort is ignored
        cycle(1'b1, 8'hA5, 1'b0, a);
        cycle(1'b1, 8'h3C, 1'b0, a);
        cycle(1'b1, 8'h77, 1'b0, a);
        cycle(1'b1, 8'h77, 1'b0, a);
        cycle(1'b1, 8'h77, 1'b1, a);
        idle(3);

        // Reset mid-frame after bit 5, then 8'h81
        cycle(1'b1, 8'h5A, 1'b0, a);
        idle(6);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_out_bit",   32'(bus.out_bit),   32'(0));
        chk("mid_rst_out_first", 32'(bus.out_first), 32'(0));
        chk("mid_rst_out_last",  32'(bus.out_last),  32'(0));
        chk("mid_rst_busy",      32'(bus.busy),      32'(0));
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'(1));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h81, 1'b0, a);
        idle(9);

        // Random traffic with occasional aborts
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 3), a);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
